// File: rtl/way_hit_select_pkg.sv
// rtl/way_hit_select_pkg.sv - default parameters and hit-way width helper for way_hit_select
package way_hit_select_pkg;

    localparam int DEF_WAYS        = 4;
    localparam int DEF_TAG_BITS    = 18;
    localparam int DEF_LINE_BITS   = 512;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_OFFSET_BITS = 6;

    // Width of the encoded hit way; never below one bit so a single-way build still has a port.
    function automatic int hit_way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/way_tag_match.sv
// rtl/way_tag_match.sv - single-way tag comparison qualified by the way's valid bit
module way_tag_match #(
    parameter int TAG_BITS = 18
) (
    input  logic [TAG_BITS-1:0] stored_tag,
    input  logic [TAG_BITS-1:0] lookup_tag,
    input  logic                valid,
    output logic                match
);

    assign match = valid && (stored_tag == lookup_tag);

endmodule

// File: rtl/way_hit_select.sv
// rtl/way_hit_select.sv - registered cache way hit detect, line select and word extract
// Optional multi-hit flag output enabled by MULTI_HIT_CHECK_EN.
module way_hit_select
    import way_hit_select_pkg::*;
#(
    parameter int WAYS        = DEF_WAYS,
    parameter int TAG_BITS    = DEF_TAG_BITS,
    parameter int LINE_BITS   = DEF_LINE_BITS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_req,
    input  logic [TAG_BITS-1:0]               i_tag,
    input  logic [OFFSET_BITS-1:0]            i_offset,
    input  logic [WAYS*TAG_BITS-1:0]          i_way_tag,
    input  logic [WAYS-1:0]                   i_way_valid,
    input  logic [WAYS*LINE_BITS-1:0]         i_way_line,
    output logic                              o_valid,
    output logic                              o_hit,
    output logic [hit_way_bits(WAYS)-1:0]     o_hit_way,
    output logic [WAYS-1:0]                   o_sel,
    output logic [LINE_BITS-1:0]              o_line,
    output logic [DATA_WIDTH-1:0]             o_word
`ifdef MULTI_HIT_CHECK_EN
    ,
    output logic                              o_multi_hit
`endif
);

    localparam int HW = hit_way_bits(WAYS);

    logic [WAYS-1:0]          match;
    logic [WAYS-1:0]          sel;
    logic [HW-1:0]            hit_way;
    logic [LINE_BITS-1:0]     sel_line;
    logic [DATA_WIDTH-1:0]    sel_word;
    logic [OFFSET_BITS-3:0]   word_idx;

    for (genvar w = 0; w < WAYS; w++) begin : g_match
        way_tag_match #(
            .TAG_BITS(TAG_BITS)
        ) u_match (
            .stored_tag(i_way_tag[w*TAG_BITS +: TAG_BITS]),
            .lookup_tag(i_tag),
            .valid     (i_way_valid[w]),
            .match     (match[w])
        );
    end

    // Scan from the top so the lowest matching way is the one left standing.
    always_comb begin
        sel     = '0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                sel     = '0;
                sel[w]  = 1'b1;
                hit_way = HW'(w);
            end
        end
    end

    always_comb begin
        sel_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (sel[w]) begin
                sel_line = i_way_line[w*LINE_BITS +: LINE_BITS];
            end
        end
    end

    // The low two offset bits are dropped, so any byte offset lands inside an aligned word.
    assign word_idx = i_offset[OFFSET_BITS-1:2];
    assign sel_word = DATA_WIDTH'(sel_line >> (word_idx * DATA_WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid   <= 1'b0;
            o_hit     <= 1'b0;
            o_hit_way <= '0;
            o_sel     <= '0;
            o_line    <= '0;
            o_word    <= '0;
        end else begin
            o_valid <= i_req;
            if (i_req) begin
                o_hit     <= |match;
                o_hit_way <= hit_way;
                o_sel     <= sel;
                o_line    <= sel_line;
                o_word    <= sel_word;
            end
        end
    end

`ifdef MULTI_HIT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_multi_hit <= 1'b0;
        end else if (i_req) begin
            o_multi_hit <= ($countones(match) > 1);
        end
    end
`endif

endmodule

// File: tb/tb_way_hit_select.sv
// tb/tb_way_hit_select.sv - randomized and directed self-checking bench for way_hit_select
module tb_way_hit_select;

    localparam int WAYS = 4;
    localparam int TB   = 18;
    localparam int LB   = 512;
    localparam int DW   = 32;
    localparam int OB   = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0;
    logic [TB-1:0]     i_tag = '0;
    logic [OB-1:0]     i_offset = '0;
    logic [WAYS*TB-1:0] i_way_tag;
    logic [WAYS-1:0]   i_way_valid = '0;
    logic [WAYS*LB-1:0] i_way_line;
    logic              o_valid, o_hit;
    logic [1:0]        o_hit_way;
    logic [WAYS-1:0]   o_sel;
    logic [LB-1:0]     o_line;
    logic [DW-1:0]     o_word;
`ifdef MULTI_HIT_CHECK_EN
    logic              o_multi_hit;
`endif

    logic [TB-1:0] tags  [WAYS];
    logic [LB-1:0] lines [WAYS];

    logic          exp_valid, exp_hit, exp_multi;
    logic [1:0]    exp_way;
    logic [3:0]    exp_sel;
    logic [LB-1:0] exp_line;
    logic [DW-1:0] exp_word;

    int total = 0;
    int bad   = 0;

    way_hit_select dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_tag      (i_tag),
        .i_offset   (i_offset),
        .i_way_tag  (i_way_tag),
        .i_way_valid(i_way_valid),
        .i_way_line (i_way_line),
        .o_valid    (o_valid),
        .o_hit      (o_hit),
        .o_hit_way  (o_hit_way),
        .o_sel      (o_sel),
        .o_line     (o_line),
        .o_word     (o_word)
`ifdef MULTI_HIT_CHECK_EN
        ,
        .o_multi_hit(o_multi_hit)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            i_way_tag[w*TB +: TB]  = tags[w];
            i_way_line[w*LB +: LB] = lines[w];
        end
    end

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_valid = 0; exp_hit = 0; exp_multi = 0;
        exp_way = 0; exp_sel = 0; exp_line = '0; exp_word = '0;
    endtask

    // Lookup as the rules describe it: first valid way whose tag equals the request tag.
    task automatic model_capture();
        int first;
        int count;
        logic [LB-1:0] ln;
        first = -1;
        count = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (i_way_valid[w] && tags[w] == i_tag) begin
                count++;
                if (first < 0) first = w;
            end
        end
        exp_valid = 1;
        exp_multi = (count > 1);
        if (first >= 0) begin
            ln       = lines[first];
            exp_hit  = 1;
            exp_way  = 2'(first);
            exp_sel  = 4'(1 << first);
            exp_line = ln;
            exp_word = ln[32*int'(i_offset[5:2]) +: 32];
        end else begin
            exp_hit = 0; exp_way = 0; exp_sel = 0; exp_line = '0; exp_word = '0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, LB'(o_valid), LB'(exp_valid));
        check({tag, ".hit"},   LB'(o_hit),   LB'(exp_hit));
        check({tag, ".way"},   LB'(o_hit_way), LB'(exp_way));
        check({tag, ".sel"},   LB'(o_sel),   LB'(exp_sel));
        check({tag, ".line"},  o_line,       exp_line);
        check({tag, ".word"},  LB'(o_word),  LB'(exp_word));
`ifdef MULTI_HIT_CHECK_EN
        check({tag, ".multi"}, LB'(o_multi_hit), LB'(exp_multi));
`endif
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle(input logic req, input string tag);
        i_req = req;
        @(posedge clk);
        if (rst) model_reset();
        else if (req) model_capture();
        else exp_valid = 0;
        #1 compare_all(tag);
        @(negedge clk);
    endtask

    task automatic rand_lines();
        for (int w = 0; w < WAYS; w++) begin
            for (int k = 0; k < LB / 32; k++) lines[w][k*32 +: 32] = $urandom;
            tags[w] = TB'($urandom);
        end
    endtask

    initial begin
        rand_lines();
        model_reset();
        #2 compare_all("reset");
        @(negedge clk);
        i_tag = tags[0]; i_way_valid = 4'hF;
        cycle(1'b1, "req_in_reset");
        rst = 1'b0;
        cycle(1'b0, "after_release");

        rand_lines();
        tags[0] = 18'h00001; tags[1] = 18'h00002; tags[2] = 18'h00ABC; tags[3] = 18'h00003;
        i_tag = 18'h00ABC; i_way_valid = 4'hF; i_offset = 6'd20;
        cycle(1'b1, "way2_hit");
        check("way2_line_direct", o_line, lines[2]);

        tags[1] = 18'h00ABC; tags[2] = 18'h00555; i_way_valid = 4'b1101;
        cycle(1'b1, "invalid_way1");
        cycle(1'b0, "hold_after_miss");

        tags[0] = 18'h1; tags[1] = 18'h3FF00; tags[2] = 18'h2; tags[3] = 18'h3FF00;
        i_tag = 18'h3FF00; i_way_valid = 4'hF;
        cycle(1'b1, "multi_1_3");
        check("multi_sel_direct", LB'(o_sel), LB'(4'b0010));

        lines[2][95:64] = 32'hDEADBEEF; tags[2] = 18'h00777; i_tag = 18'h00777;
        i_offset = 6'd8;
        cycle(1'b1, "word_off8");
        check("deadbeef_off8", LB'(o_word), LB'(32'hDEADBEEF));
        i_offset = 6'd11;
        cycle(1'b1, "word_off11");
        check("deadbeef_off11", LB'(o_word), LB'(32'hDEADBEEF));
        cycle(1'b0, "hold_word");

        tags[0] = 18'h10; tags[1] = 18'h11; tags[2] = 18'h12; tags[3] = 18'h13;
        i_tag = 18'h10; cycle(1'b1, "seq_w0");
        i_tag = 18'h13; cycle(1'b1, "seq_w3");
        i_tag = 18'h11; cycle(1'b1, "seq_w1");
        cycle(1'b0, "seq_end");

        // Asynchronous reset mid-cycle must clear outputs without a clock edge.
        i_tag = 18'h12; cycle(1'b1, "pre_reset");
        #2 rst = 1'b1;
        #1 model_reset(); compare_all("async_reset");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, "pulse_req");
        cycle(1'b0, "pulse_end");
        cycle(1'b0, "pulse_idle");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) rand_lines();
            for (int w = 0; w < WAYS; w++)
                if ($urandom_range(0, 3) == 0) tags[w] = tags[$urandom_range(0, 3)];
            i_way_valid = 4'($urandom);
            i_offset    = 6'($urandom);
            i_tag       = ($urandom_range(0, 9) < 7) ? tags[$urandom_range(0, 3)] : TB'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
